// File: rtl/cva6_fifo_stream_out.sv
// rtl/cva6_fifo_stream_out.sv - registered valid/ready output stage for a non-fall-through FIFO (optional stall counter: CVA6_FIFO_STREAM_OUT_STATS_EN)
module cva6_fifo_stream_out #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter type         dtype           = logic [DATA_WIDTH-1:0],
  parameter int unsigned STALL_CNT_WIDTH = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       fifo_empty_i,
  input  dtype                       fifo_data_i,
  output logic                       fifo_pop_o,
  output logic                       valid_o,
  input  logic                       ready_i,
  output dtype                       data_o,
  output logic [STALL_CNT_WIDTH-1:0] stall_cnt_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } cnt_e;

  cnt_e cnt_q;
  dtype slot0_q;
  dtype slot1_q;
  logic enq;
  logic deq;

  // Pop never looks at ready_i, so the consumer stays off the FIFO pop path.
  assign fifo_pop_o = ~fifo_empty_i & (cnt_q != TWO) & ~flush_i;
  assign valid_o    = (cnt_q != EMPTY) & ~flush_i;
  assign data_o     = slot0_q;
  assign enq        = fifo_pop_o;
  assign deq        = valid_o & ready_i;

  // Occupancy FSM and skid slots; slot0 is always the head of the stream.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q   <= EMPTY;
      slot0_q <= '0;
      slot1_q <= '0;
    end else if (flush_i) begin
      cnt_q <= EMPTY;
    end else begin
      unique case (cnt_q)
        EMPTY: begin
          if (enq) begin
            cnt_q   <= ONE;
            slot0_q <= fifo_data_i;
          end
        end
        ONE: begin
          if (enq && deq) begin
            slot0_q <= fifo_data_i;
          end else if (enq) begin
            cnt_q   <= TWO;
            slot1_q <= fifo_data_i;
          end else if (deq) begin
            cnt_q <= EMPTY;
          end
        end
        TWO: begin
          if (deq) begin
            cnt_q   <= ONE;
            slot0_q <= slot1_q;
          end
        end
        default: cnt_q <= EMPTY;
      endcase
    end
  end

`ifdef CVA6_FIFO_STREAM_OUT_STATS_EN
  logic [STALL_CNT_WIDTH-1:0] stall_cnt_q;

  // Saturating count of cycles the consumer holds off a valid head; flush leaves it alone.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
    end else if (valid_o && !ready_i && !(&stall_cnt_q)) begin
      stall_cnt_q <= stall_cnt_q + STALL_CNT_WIDTH'(1);
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: doc/cva6_fifo_stream_out.md
# cva6_fifo_stream_out

Output stage placed directly downstream of a CVA6 non-fall-through FIFO. It converts the FIFO's empty/pop interface into a registered valid/ready stream. A two-entry skid buffer gives full throughput while keeping `ready_i` off the combinational path to the FIFO's `pop_i`. Consumers such as issue or commit stages get a registered `data_o` and a flush shared with the FIFO.

## Interface
Parameters:
- `DATA_WIDTH`, 32: payload width when `dtype` is left at its default.
- `dtype`, `logic [DATA_WIDTH-1:0]`: payload type, identical to the upstream FIFO's `dtype`.
- `STALL_CNT_WIDTH`, 16: width of the stall counter.

Ports (one clock; reset is asynchronous and active-high):
- `clk_i`  in  1: clock, rising edge.
- `rst_i`  in  1: asynchronous active-high reset.
- `flush_i`  in  1: discard buffered entries; wired to the same flush as the FIFO.
- `fifo_empty_i`  in  1: FIFO `empty_o`.
- `fifo_data_i`  in  `$bits(dtype)`: FIFO `data_o` (head entry).
- `fifo_pop_o`  out  1: FIFO `pop_i`.
- `valid_o`  out  1: `data_o` is valid.
- `ready_i`  in  1: consumer accepts `data_o`.
- `data_o`  out  `$bits(dtype)`: head payload.
- `stall_cnt_o`  out  `STALL_CNT_WIDTH`: saturating backpressure count (see Configuration).

## Operation
Storage and state:
- Two registers: `slot0_q` (head, drives `data_o`) and `slot1_q`.
- Occupancy state `cnt_q` ∈ {EMPTY=0, ONE=1, TWO=2}.

Combinational outputs:
- `fifo_pop_o = ~fifo_empty_i & (cnt_q != TWO) & ~flush_i`. This depends only on registered state, `fifo_empty_i` and `flush_i`, never on `ready_i`.
- `valid_o = (cnt_q != EMPTY) & ~flush_i`.
- Events: `enq = fifo_pop_o`; `deq = valid_o & ready_i`.

Transitions (when `flush_i`=0):
- EMPTY:
  - `enq` → ONE, `slot0 <= fifo_data_i`.
  - otherwise hold.
- ONE:
  - `enq & deq` → ONE, `slot0 <= fifo_data_i`.
  - `enq & ~deq` → TWO, `slot1 <= fifo_data_i`.
  - `~enq & deq` → EMPTY.
  - neither → hold.
- TWO (`enq` is 0 by construction):
  - `deq` → ONE, `slot0 <= slot1`.
  - otherwise hold, with slots stable.

Rules:
- `flush_i`=1 forces the next state to EMPTY. The slot contents are don't-care and are not cleared.
- Ordering is strict FIFO. An entry is never dropped or duplicated except by flush.
- `data_o` is stable while `valid_o & ~ready_i`. This is the AXI-style hold rule.

## Timing
- Reset values: `cnt_q`=EMPTY, slots=0, `stall_cnt`=0.
  - Therefore `valid_o`=0 and `data_o`=0.
  - `fifo_pop_o` follows `fifo_empty_i`; the reset FIFO reports empty, so it is 0.
- Reset asserted mid-operation returns to EMPTY immediately (asynchronous). Buffered entries are lost.
- Latency: an entry popped at edge N is presented with `valid_o`=1 in cycle N+1.
  - Minimum FIFO-head-to-`valid_o` latency: 1 cycle.
- Throughput: 1 entry/cycle sustained with `ready_i`=1 and the FIFO non-empty. State stays in ONE.
- Backpressure: after `ready_i` drops, at most one further entry is popped (ONE→TWO). Popping then stops in TWO.
- Simultaneous `flush_i` and `ready_i`:
  - No transfer occurs, because `valid_o` is forced to 0.
  - No pop occurs.
- The FIFO must be non-fall-through. `fifo_data_i` is sampled only at edges where `fifo_pop_o`=1.

## Configuration
Macro `CVA6_FIFO_STREAM_OUT_STATS_EN`:
- Defined:
  - `stall_cnt_q` increments each cycle `valid_o & ~ready_i`.
  - It saturates at all-ones, clears on `rst_i`, and is not cleared by flush.
  - `stall_cnt_o = stall_cnt_q`.
- Undefined: no counter register is built, and `stall_cnt_o` is tied to 0.
- The port exists in both builds.

## Test plan
- **Reset:** assert `rst_i` with `fifo_empty_i`=1 → `valid_o`=0, `fifo_pop_o`=0, `stall_cnt_o`=0; same result when reset is asserted mid-stream in state TWO.
- **Streaming:** FIFO holds 0xA0..0xA7, `ready_i`=1 → first `valid_o` one cycle after the first pop; `data_o` = 0xA0..0xA7 on 8 consecutive cycles; `cnt_q` stays ONE.
- **Backpressure:**
  - Stimulus: FIFO holds 0x10,0x11,0x12; hold `ready_i`=0 for 5 cycles, then release.
  - Popping: exactly two pops occur, then `fifo_pop_o`=0 while `data_o` stays 0x10.
  - After release: 0x10,0x11,0x12 are delivered in order.
  - With the macro defined, `stall_cnt_o`=4.
- **Flush:** in state TWO (0x20,0x21), assert `flush_i` for 1 cycle with `ready_i`=1 → no transfer that cycle and `fifo_pop_o`=0; next cycle `valid_o`=0.
- **Saturation:** with the macro defined and `STALL_CNT_WIDTH`=4, hold `ready_i`=0 for 20 cycles with `valid_o`=1 → `stall_cnt_o`=15 and holds.
- **Random:** random `fifo_empty_i`/`ready_i` against a scoreboard for 10k cycles → no loss or reorder; `fifo_pop_o` is never 1 in TWO; no `ready_i`→`fifo_pop_o` combinational dependency (checked by toggling `ready_i` alone).
